// File: rtl/unary_add_driver.sv
// Host driver for a unary adder: serialises two binary operands as unary streams,
// then drains the adder's unary result back into a binary sum with carry/overrun flags.
module unary_add_driver #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             err,
   output logic             ua_out,
   output logic             ub_out,
   output logic             en_out,
   output logic             rw_out,
   input  logic             dout_in,
   input  logic             c_in
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   localparam logic [WIDTH-1:0] SUM_MAX = '1;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, a_n, b_q, b_n, len_q, len_n, cnt_q, cnt_n;
   logic             first_q, first_n;
   logic [WIDTH-1:0] sum_n;
   logic             carry_n, err_n, busy_n, done_n;
   logic             ua_n, ub_n, en_n, rw_n;
   logic [WIDTH-1:0] op_max_c;

   assign op_max_c = (op_a > op_b) ? op_a : op_b;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         sum     <= '0;
         carry   <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ua_out  <= 1'b0;
         ub_out  <= 1'b0;
         en_out  <= 1'b0;
         rw_out  <= 1'b0;
      end else begin
         state   <= state_n;
         a_q     <= a_n;
         b_q     <= b_n;
         len_q   <= len_n;
         cnt_q   <= cnt_n;
         first_q <= first_n;
         sum     <= sum_n;
         carry   <= carry_n;
         err     <= err_n;
         busy    <= busy_n;
         done    <= done_n;
         ua_out  <= ua_n;
         ub_out  <= ub_n;
         en_out  <= en_n;
         rw_out  <= rw_n;
      end
   end

   // Next state and next output values; outputs describe the upcoming cycle
   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      len_n   = len_q;
      cnt_n   = cnt_q;
      first_n = first_q;
      sum_n   = sum;
      carry_n = carry;
      err_n   = err;
      busy_n  = busy;
      done_n  = 1'b0;
      ua_n    = 1'b0;
      ub_n    = 1'b0;
      en_n    = en_out;
      rw_n    = rw_out;

      case (state)
         IDLE: begin
            if (start) begin
               a_n     = op_a;
               b_n     = op_b;
               len_n   = op_max_c;
               sum_n   = '0;
               carry_n = 1'b0;
               err_n   = 1'b0;
               busy_n  = 1'b1;
               en_n    = 1'b1;
               cnt_n   = WIDTH'(1);
               if (op_max_c != '0) begin
                  state_n = FEED;
                  rw_n    = 1'b0;
                  ua_n    = (op_a != '0);
                  ub_n    = (op_b != '0);
               end else begin
                  state_n = DRAIN;
                  rw_n    = 1'b1;
                  first_n = 1'b1;
               end
            end
         end

         FEED: begin
            // c_in reflects the previous cycle's stimulus
            if (cnt_q >= WIDTH'(2)) carry_n = carry | c_in;
            if (cnt_q == len_q) begin
               state_n = DRAIN;
               rw_n    = 1'b1;
               first_n = 1'b1;
            end else begin
               cnt_n = cnt_q + WIDTH'(1);
               ua_n  = (cnt_q < a_q);
               ub_n  = (cnt_q < b_q);
            end
         end

         DRAIN: begin
            if (first_q) begin
               carry_n = carry | c_in;
               first_n = 1'b0;
            end else if (dout_in && (sum != SUM_MAX)) begin
               sum_n = sum + WIDTH'(1);
            end else begin
               err_n   = err | dout_in;
               state_n = DONE;
               done_n  = 1'b1;
               en_n    = 1'b0;
               rw_n    = 1'b0;
            end
         end

         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_unary_add_driver.sv
// Scoreboard bench for unary_add_driver against a behavioural unary adder model
// (plus a stuck-at-one dout stub for the overrun case).
module tb_unary_add_driver;

   localparam int unsigned WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst, start, stub;
   logic [WIDTH-1:0] op_a, op_b;
   logic             busy, done, carry, err, ua_out, ub_out, en_out, rw_out;
   logic [WIDTH-1:0] sum;
   logic             dout_in, c_in;

   logic [WIDTH-1:0] ad_cnt;
   logic             ad_c, ad_dout;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             err;
      int               cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   unary_add_driver #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .err(err),
      .ua_out(ua_out), .ub_out(ub_out), .en_out(en_out), .rw_out(rw_out),
      .dout_in(dout_in), .c_in(c_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unary adder: accumulate in read phase, emit one dout per count in write phase
   always @(posedge clk) begin
      if (rst) begin
         ad_cnt  <= '0;
         ad_c    <= 1'b0;
         ad_dout <= 1'b0;
      end else if (!en_out) begin
         ad_c    <= 1'b0;
         ad_dout <= 1'b0;
      end else if (!rw_out) begin
         {ad_c, ad_cnt} <= 6'(ad_cnt) + 6'(ua_out) + 6'(ub_out);
         ad_dout        <= 1'b0;
      end else begin
         ad_c <= 1'b0;
         if (ad_cnt != '0) begin
            ad_dout <= 1'b1;
            ad_cnt  <= ad_cnt - 5'd1;
         end else begin
            ad_dout <= 1'b0;
         end
      end
   end

   assign dout_in = stub ? 1'b1 : ad_dout;
   assign c_in    = ad_c;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
         end else begin
            mon_e = q.pop_front();
            chk("sum",     int'(sum),    int'(mon_e.sum));
            chk("carry",   int'(carry),  int'(mon_e.carry));
            chk("err",     int'(err),    int'(mon_e.err));
            chk("latency", cyc,          mon_e.cyc);
            chk("done_en", int'(en_out), 0);
            chk("done_rw", int'(rw_out), 0);
            chk("done_busy", int'(busy), 1);
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] es, input logic ec, input logic ee,
                        input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.sum   = es;
         e.carry = ec;
         e.err   = ee;
         e.cyc   = cyc + lat;
         q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=busy required=idle");
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stub  = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_en",   int'(en_out), 0);
      chk("rst_sum",  int'(sum), 0);
      @(negedge clk);
      rst = 1'b0;

      // 3+5: check the unary streams during FEED, then the switch to DRAIN
      issue(5'd3, 5'd5, 5'd8, 1'b0, 1'b0, 15, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("feed_ua", int'(ua_out), (i < 3) ? 1 : 0);
         chk("feed_ub", int'(ub_out), 1);
         chk("feed_en", int'(en_out), 1);
         chk("feed_rw", int'(rw_out), 0);
         @(posedge clk);
         #1;
      end
      chk("drain_rw", int'(rw_out), 1);
      chk("drain_ua", int'(ua_out), 0);
      wait_idle();

      issue(5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 2,  1'b1);
      wait_idle();
      issue(5'd31, 5'd1,  5'd0, 1'b1, 1'b0, 33, 1'b1);
      wait_idle();
      issue(5'd20, 5'd20, 5'd8, 1'b1, 1'b0, 30, 1'b1);
      wait_idle();
      issue(5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 7,  1'b1);
      wait_idle();

      // start while busy must be ignored
      issue(5'd3, 5'd5, 5'd8, 1'b0, 1'b0, 15, 1'b1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      op_a  = 5'd7;
      op_b  = 5'd9;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset in the middle of DRAIN aborts without a done pulse
      issue(5'd10, 5'd4, 5'd0, 1'b0, 1'b0, 0, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      chk("pre_rst_rw", int'(rw_out), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_en",   int'(en_out), 0);
      chk("abort_rw",   int'(rw_out), 0);
      chk("abort_sum",  int'(sum), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_busy", int'(busy), 0);
      issue(5'd6, 5'd7, 5'd13, 1'b0, 1'b0, 22, 1'b1);
      wait_idle();

      // stuck-at-one dout: sum saturates and err is raised
      stub = 1'b1;
      issue(5'd0, 5'd0, 5'd31, 1'b0, 1'b1, 33, 1'b1);
      wait_idle();
      stub = 1'b0;
      chk("stub_en_after", int'(en_out), 0);

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
